// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between two byte requesters, the scheduler and a UART transmitter.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface uart_tx_sched_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       grant_id;
  logic       sched_busy;
  logic       timeout_err;
  logic       err_clear;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_busy, err_clear,
    output req0_ready, req1_ready, tx_start, tx_data, grant_id, sched_busy, timeout_err
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_busy, err_clear,
    input  req0_ready, req1_ready, tx_start, tx_data, grant_id, sched_busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin byte scheduler in front of a UART transmitter,
// with a busy-rise timeout and an enforced idle gap between frames.
//
// state     | meaning
// IDLE      | arbitrating, ready offered to the selected requester
// START     | tx_start held high, waiting for tx_busy to rise (bounded)
// WAIT_DONE | transmitter shifting, waiting for tx_busy to fall
// GAP       | enforced idle cycles before the next acceptance
module uart_tx_sched #(
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 255
) (
  input logic            wb_clk_i,
  input logic            wb_rst_i,
  uart_tx_sched_if.slave bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] GAP       = 2'd3;

  // A zero gap skips GAP entirely rather than spending one cycle there.
  localparam logic [1:0] AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;
  localparam logic [7:0] TO_LAST     = 8'(BUSY_TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] cnt;
  logic       last_grant;
  logic       sel;
  logic       idle;
  logic       ready0;
  logic       ready1;
  logic       accept;
  logic       timeout_hit;
  logic [7:0] data_q;
  logic       grant_q;
  logic       err_q;

  assign idle = (state == IDLE);

  // On a tie the requester that did not own the previous frame wins.
  assign sel = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;

  assign ready0 = idle && !wb_rst_i && bus.req0_valid && !sel;
  assign ready1 = idle && !wb_rst_i && bus.req1_valid && sel;
  assign accept = ready0 || ready1;

  // The counter value before the increment that would reach BUSY_TIMEOUT.
  assign timeout_hit = (state == START) && !bus.tx_busy && (cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = START;
      START: begin
        if (bus.tx_busy)           state_nxt = WAIT_DONE;
        else if (cnt == TO_LAST)   state_nxt = AFTER_FRAME;
      end
      WAIT_DONE: if (!bus.tx_busy) state_nxt = AFTER_FRAME;
      GAP:       if (cnt == GAP_LAST) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      data_q     <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= 8'd0;
      else if (state == START || state == GAP)
        cnt <= cnt + 8'd1;

      if (accept) begin
        data_q     <= sel ? bus.req1_data : bus.req0_data;
        grant_q    <= sel;
        last_grant <= sel;
      end

      if (timeout_hit)
        err_q <= 1'b1;
      else if (bus.err_clear)
        err_q <= 1'b0;
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.tx_start    = (state == START);
  assign bus.tx_data     = data_q;
  assign bus.grant_id    = grant_q;
  assign bus.sched_busy  = !idle;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: default instance plus a GAP_CYCLES=0 instance.
module tb_uart_tx_sched;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic busy_auto = 1'b0;

  uart_tx_sched_if bus ();
  uart_tx_sched_if bus_g ();

  uart_tx_sched dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus.slave));
  uart_tx_sched #(.GAP_CYCLES(0)) dut_g0 (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus_g.slave));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: busy rises 3 cycles after tx_start is first seen, lasts 10 cycles.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      tick();
      if (busy_auto && bus.tx_start) begin
        repeat (3) tick();
        bus.tx_busy = 1'b1;
        repeat (10) tick();
        bus.tx_busy = 1'b0;
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.sched_busy && n < 400) begin tick(); n++; end
    checks++; if (bus.sched_busy !== 1'b0) begin errors++; $display("FAIL %s_idle_timeout: sched_busy=%b want 0", name, bus.sched_busy); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #3;
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start: got %b want 0", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h want 00", bus.tx_data); end
    checks++; if (bus.grant_id !== 1'b0) begin errors++; $display("FAIL rst_grant_id: got %b want 0", bus.grant_id); end
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0: got %b want 0", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1: got %b want 0", bus.req1_ready); end
    checks++; if (bus.sched_busy !== 1'b0) begin errors++; $display("FAIL rst_sched_busy: got %b want 0", bus.sched_busy); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b want 0", bus.timeout_err); end
    repeat (2) tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame;
    int n = 0;
    busy_auto = 1'b1;
    bus.req0_data = 8'h0F; bus.req0_valid = 1'b1;
    #1;
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", {bus.req1_ready, bus.req0_ready}); end
    tick();
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_once: got %b want 0", bus.req0_ready); end
    bus.req0_valid = 1'b0;
    checks++; if (bus.tx_data !== 8'h0F) begin errors++; $display("FAIL single_tx_data: got %h want 0f", bus.tx_data); end
    checks++; if (bus.grant_id !== 1'b0) begin errors++; $display("FAIL single_grant: got %b want 0", bus.grant_id); end
    while (bus.tx_start && n < 50) begin n++; tick(); end
    checks++; if (n !== 4) begin errors++; $display("FAIL single_start_len: got %0d want 4", n); end
    n = 0;
    while (bus.tx_busy && n < 50) begin n++; tick(); end
    tick();
    checks++; if (bus.sched_busy !== 1'b1) begin errors++; $display("FAIL single_gap1: sched_busy=%b want 1", bus.sched_busy); end
    tick();
    checks++; if (bus.sched_busy !== 1'b1) begin errors++; $display("FAIL single_gap2: sched_busy=%b want 1", bus.sched_busy); end
    tick();
    checks++; if (bus.sched_busy !== 1'b0) begin errors++; $display("FAIL single_idle: sched_busy=%b want 0", bus.sched_busy); end
  endtask

  task automatic test_alternation;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    busy_auto = 1'b1;
    bus.req0_data = 8'h0F; bus.req1_data = 8'h3D;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      int g = 0;
      logic [1:0] exp_rdy;
      logic [7:0] exp_data;
      logic       exp_id;
      exp_id   = i[0];
      exp_rdy  = exp_id ? 2'b10 : 2'b01;
      exp_data = exp_id ? 8'h3D : 8'h0F;
      while (!(bus.req0_ready || bus.req1_ready) && g < 100) begin tick(); g++; end
      checks++; if ({bus.req1_ready, bus.req0_ready} !== exp_rdy) begin errors++; $display("FAIL alt_ready[%0d]: got %b want %b", i, {bus.req1_ready, bus.req0_ready}, exp_rdy); end
      tick();
      checks++; if (bus.tx_data !== exp_data) begin errors++; $display("FAIL alt_tx_data[%0d]: got %h want %h", i, bus.tx_data, exp_data); end
      checks++; if (bus.grant_id !== exp_id) begin errors++; $display("FAIL alt_grant[%0d]: got %b want %b", i, bus.grant_id, exp_id); end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_idle("alt");
  endtask

  task automatic test_timeout;
    int n = 0;
    busy_auto = 1'b0;
    bus.req1_data = 8'h3D; bus.req1_valid = 1'b1;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL to_ready1: got %b want 1", bus.req1_ready); end
    tick();
    bus.req1_valid = 1'b0;
    while (bus.tx_start && n < 400) begin n++; tick(); end
    checks++; if (n !== 255) begin errors++; $display("FAIL to_start_len: got %0d want 255", n); end
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set: got %b want 1", bus.timeout_err); end
    checks++; if (bus.tx_data !== 8'h3D) begin errors++; $display("FAIL to_tx_data_hold: got %h want 3d", bus.tx_data); end
    repeat (5) tick();
    checks++; if ({bus.timeout_err, bus.sched_busy} !== 2'b10) begin errors++; $display("FAIL to_err_sticky: got err,busy=%b want 10", {bus.timeout_err, bus.sched_busy}); end
    bus.err_clear = 1'b1; tick(); bus.err_clear = 1'b0;
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b want 0", bus.timeout_err); end
    bus.req0_data = 8'h55; bus.req0_valid = 1'b1;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL to_next_accept: got %b want 1", bus.req0_ready); end
    tick();
    bus.req0_valid = 1'b0;
    checks++; if (bus.tx_data !== 8'h55) begin errors++; $display("FAIL to_next_data: got %h want 55", bus.tx_data); end
    repeat (254) tick();
    checks++; if ({bus.tx_start, bus.timeout_err} !== 2'b10) begin errors++; $display("FAIL to_last_cycle: got start,err=%b want 10", {bus.tx_start, bus.timeout_err}); end
    bus.err_clear = 1'b1; tick(); bus.err_clear = 1'b0;
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_set_wins: got %b want 1", bus.timeout_err); end
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL to_start_drop: got %b want 0", bus.tx_start); end
    wait_idle("to");
  endtask

  task automatic test_reset_mid_frame;
    int n = 0;
    busy_auto = 1'b1;
    bus.req0_data = 8'hA7; bus.req0_valid = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    while (bus.tx_start && n < 50) begin n++; tick(); end
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL rmid_tx_start: got %b want 0", bus.tx_start); end
    checks++; if (bus.sched_busy !== 1'b0) begin errors++; $display("FAIL rmid_sched_busy: got %b want 0", bus.sched_busy); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rmid_timeout_err: got %b want 0", bus.timeout_err); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rmid_tx_data: got %h want 00", bus.tx_data); end
    bus.req0_data = 8'h0F; bus.req1_data = 8'h3D;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin errors++; $display("FAIL rmid_ready_in_rst: got %b want 00", {bus.req1_ready, bus.req0_ready}); end
    n = 0;
    while (bus.tx_busy && n < 30) begin n++; tick(); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin errors++; $display("FAIL rmid_first_grant: got %b want 01", {bus.req1_ready, bus.req0_ready}); end
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    checks++; if ({bus.tx_start, bus.grant_id, bus.tx_data} !== {1'b1, 1'b0, 8'h0F}) begin errors++; $display("FAIL rmid_frame: got start,id,data=%b,%b,%h want 1,0,0f", bus.tx_start, bus.grant_id, bus.tx_data); end
    wait_idle("rmid");
  endtask

  task automatic test_back_to_back;
    bus_g.req0_data = 8'h01; bus_g.req0_valid = 1'b1;
    #1;
    checks++; if (bus_g.req0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_first: got %b want 1", bus_g.req0_ready); end
    tick();
    checks++; if ({bus_g.tx_start, bus_g.tx_data} !== {1'b1, 8'h01}) begin errors++; $display("FAIL b2b_first: got start,data=%b,%h want 1,01", bus_g.tx_start, bus_g.tx_data); end
    bus_g.req0_data = 8'h02;
    bus_g.tx_busy = 1'b1;
    tick();
    checks++; if ({bus_g.tx_start, bus_g.req0_ready} !== 2'b00) begin errors++; $display("FAIL b2b_wait: got start,ready=%b want 00", {bus_g.tx_start, bus_g.req0_ready}); end
    tick();
    bus_g.tx_busy = 1'b0;
    #1;
    checks++; if (bus_g.req0_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_early: got %b want 0", bus_g.req0_ready); end
    tick();
    checks++; if ({bus_g.sched_busy, bus_g.req0_ready} !== 2'b01) begin errors++; $display("FAIL b2b_second_accept: got busy,ready=%b want 01", {bus_g.sched_busy, bus_g.req0_ready}); end
    tick();
    bus_g.req0_valid = 1'b0;
    checks++; if ({bus_g.tx_start, bus_g.tx_data} !== {1'b1, 8'h02}) begin errors++; $display("FAIL b2b_second: got start,data=%b,%h want 1,02", bus_g.tx_start, bus_g.tx_data); end
    bus_g.tx_busy = 1'b1; repeat (2) tick();
    bus_g.tx_busy = 1'b0; repeat (2) tick();
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req0_data = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_data = 8'h00;
    bus.err_clear  = 1'b0;
    bus_g.req0_valid = 1'b0; bus_g.req0_data = 8'h00;
    bus_g.req1_valid = 1'b0; bus_g.req1_data = 8'h00;
    bus_g.err_clear  = 1'b0; bus_g.tx_busy = 1'b0;
    test_reset();
    test_single_frame();
    test_alternation();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter GAP_CYCLES, default 2: idle cycles enforced between the end of one frame and the next acceptance; legal range 0..15.
REQ-002 Parameter BUSY_TIMEOUT, default 255: maximum cycles to wait for tx_busy to rise after tx_start is asserted; legal range 1..255.
REQ-003 Port wb_clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port wb_rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port req0_valid, input, 1 bit: requester 0 has a byte to send.
REQ-006 Port req0_data, input, 8 bits: requester 0 byte.
REQ-007 Port req0_ready, output, 1 bit: scheduler accepts requester 0's byte this cycle.
REQ-008 Ports req1_valid, req1_data and req1_ready: same as REQ-005 to REQ-007, for requester 1.
REQ-009 Port tx_start, output, 1 bit: start request to the UART transmitter.
REQ-010 Port tx_data, output, 8 bits: byte presented to the transmitter.
REQ-011 Port tx_busy, input, 1 bit: transmitter is shifting a frame.
REQ-012 Port grant_id, output, 1 bit: requester that owns the current or last frame.
REQ-013 Port sched_busy, output, 1 bit: high in any state other than IDLE.
REQ-014 Port timeout_err, output, 1 bit: sticky flag, set when tx_busy never rose.
REQ-015 Port err_clear, input, 1 bit: single-cycle clear of timeout_err.

Function
REQ-016 The FSM SHALL have the states IDLE, START, WAIT_DONE and GAP.
REQ-017 In IDLE, reqN_ready SHALL be combinational, and high only for the requester selected by the arbiter while that requester's valid is high.
- Never both ready outputs high in the same cycle.
- Never any ready high outside IDLE.
REQ-018 Arbitration SHALL work as follows:
- If one requester is valid, it is granted.
- If both are valid, the one not equal to last_grant is granted.
- last_grant resets to 1, so requester 0 wins the first tie.
REQ-019 Acceptance SHALL occur on a cycle where valid and ready are both high. On acceptance:
- the byte is latched into tx_data;
- grant_id and last_grant are updated;
- the FSM moves to START.
REQ-020 A requester SHALL hold data stable while valid is high and ready is low. Dropping valid before acceptance has no effect.
REQ-021 tx_start SHALL be high from the cycle after acceptance (latency 1) and for the whole of START.
REQ-022 In START, a cycle counter SHALL increment every cycle.
- tx_busy high: tx_start drops on the next cycle and the FSM moves to WAIT_DONE.
- Counter reaches BUSY_TIMEOUT with tx_busy still low: tx_start drops, timeout_err sets, the frame is discarded, and the FSM moves to GAP.
REQ-023 In WAIT_DONE, the FSM SHALL wait for tx_busy low, then move to GAP. There is no timeout in this state.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles before IDLE. If GAP_CYCLES is 0, the FSM goes from WAIT_DONE or timeout directly to IDLE.
REQ-025 tx_data SHALL hold the last accepted byte until the next acceptance.
REQ-026 err_clear SHALL clear timeout_err. If a timeout occurs in the same cycle as err_clear, set wins.
REQ-027 The counter SHALL be 8 bits, cleared on every state entry, and never wrap in START.

Reset
REQ-028 While wb_rst_i is high, outputs SHALL take these values immediately (asynchronous):
- tx_start = 0, tx_data = 0x00, grant_id = 0;
- req0_ready = 0, req1_ready = 0;
- sched_busy = 0, timeout_err = 0.
REQ-029 While wb_rst_i is high, internal state SHALL be: FSM in IDLE, counter = 0, last_grant = 1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame without a tx_start glitch. The first cycle after release is IDLE.

Verification
REQ-031 req0_valid with 0x0F, busy model rising 3 cycles after tx_start and lasting 10 cycles -> req0_ready high one cycle; tx_start high exactly 4 cycles; tx_data = 0x0F; grant_id = 0; IDLE after busy falls + 2 gap cycles.
REQ-032 req0 = 0x0F and req1 = 0x3D both valid continuously for 4 frame pairs -> tx_data sequence 0x0F, 0x3D, 0x0F, 0x3D, ... with grant_id alternating 0, 1, 0, 1, ...; no starvation.
REQ-033 tx_busy tied low, req1 = 0x3D -> tx_start high 255 cycles then low; timeout_err = 1 and stays 1; next request is accepted; err_clear pulse gives timeout_err = 0 on the next cycle.
REQ-034 wb_rst_i pulsed during WAIT_DONE -> tx_start, sched_busy and timeout_err go to 0 asynchronously; after release, with both valid, req0 is granted first.
REQ-035 GAP_CYCLES = 0 with back-to-back req0 bytes 0x01, 0x02 -> second acceptance in the cycle after tx_busy is seen low.
REQ-036 err_clear coincident with a timeout -> timeout_err remains 1.
